x3_serial_adder: RTL

X3_SERIAL_ADDER -- requirements
Module: x3_serial_adder

---
 rtl/x3_serial_adder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/x3_serial_adder.sv
// x3_serial_adder -- digit-serial excess-3 adder.
//
// Accepts two packed excess-3 operands (digit 0 in bits [3:0]) plus a carry in.
// It then adds them one digit per cycle, least significant digit first, and
// holds the result until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand set offered
//   in_ready   block is idle and can take an operand set (low during reset)
//   a, b       packed excess-3 operands, 4*NDIG bits each
//   cin        carry into digit 0
//   out_valid  result available; held until out_ready
//   out_ready  consumer takes the result
//   sum        packed excess-3 result
//   cout       carry out of the most significant digit
//   err        an operand digit was outside 0011..1100
//
// Build option
//   X3_DIGIT_CHECK_EN  when defined, each digit is range-checked as it is
//                      processed and err becomes sticky for the transaction.
//                      When undefined, err is tied to 0.
module x3_serial_adder #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } opnd_t;

    logic [1:0]    state_q, state_d;
    opnd_t         opnd_q, opnd_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    // Digit datapath: always looks at the low digit of the shifting operands.
    logic [4:0] t;
    logic [3:0] dig;
    logic       dig_c;

    logic accept;
    assign accept = (state_q == IDLE) && in_valid;

    always_comb begin
        t = {1'b0, opnd_q.a[3:0]} + {1'b0, opnd_q.b[3:0]} + {4'b0, carry_q};
        // Excess-3 correction: a decimal carry pushes the binary sum past 15,
        // so the bias must be added back; otherwise the doubled bias is removed.
        if (t[4]) begin
            dig   = t[3:0] + 4'd3;
            dig_c = 1'b1;
        end else begin
            dig   = t[3:0] - 4'd3;
            dig_c = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opnd_d.a = a;
                    opnd_d.b = b;
                    carry_d  = cin;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                opnd_d.a = opnd_q.a >> 4;
                opnd_d.b = opnd_q.b >> 4;
                carry_d  = dig_c;
                // Result digits enter at the top and walk down, so after NDIG
                // steps digit 0 sits in bits [3:0].
                sum_d    = (sum_q >> 4) | (W'(dig) << (W - 4));
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_c;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef X3_DIGIT_CHECK_EN
    logic err_q, err_d;

    function automatic logic bad_code(input logic [3:0] d);
        return (d < 4'd3) || (d > 4'd12);
    endfunction

    always_comb begin
        err_d = err_q;
        if (accept)
            err_d = 1'b0;
        else if (state_q == RUN && (bad_code(opnd_q.a[3:0]) || bad_code(opnd_q.b[3:0])))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    // accept is only consumed by the optional checker
    logic unused_ok;
    assign unused_ok = accept;

endmodule
